// File: rtl/mist_sd_arbiter.sv
// mist_sd_arbiter
// ---------------
// Shares one user_io SD-card sector interface between two requesters.
// Requesters raise rd_req[i] or wr_req[i] and hold it until done[i] or err[i].
// The arbiter grants one owner at a time. It latches that owner's sector
// address and issues sd_rd/sd_wr. It routes the byte stream to and from the
// owner during the transfer. It signals completion with a one-cycle done
// pulse, or signals a missing acknowledge with a one-cycle err pulse.
//
// Ports
//   clk_sys      in   system clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   rd_req       in   [1:0] per-requester sector-read request
//   wr_req       in   [1:0] per-requester sector-write request
//   lba_0/lba_1  in   [31:0] sector address of requester 0 / 1
//   din_0/din_1  in   [7:0] write-buffer byte of requester 0 / 1
//   grant        out  [1:0] one-hot current owner, 00 when idle
//   done         out  [1:0] completion pulse on the owner's bit
//   err          out  [1:0] timeout-abort pulse on the owner's bit
//   buff_wr      out  [1:0] sd_buff_wr routed to the owner's bit
//   sd_lba       out  [31:0] registered sector address to user_io
//   sd_rd/sd_wr  out  registered read / write request to user_io
//   sd_ack       in   user_io acknowledge, high for the whole transfer
//   sd_buff_wr   in   user_io read-data strobe
//   sd_buff_din  out  [7:0] write data to user_io
module mist_sd_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [1:0]  rd_req,
    input  logic [1:0]  wr_req,
    input  logic [31:0] lba_0,
    input  logic [31:0] lba_1,
    input  logic [7:0]  din_0,
    input  logic [7:0]  din_1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [1:0]  buff_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last count value of the acknowledge wait; abort happens on this edge.
    localparam logic [23:0] TO_LAST = TIMEOUT - 24'd1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q,    rr_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  err_q,   err_d;
    logic        rd_q,    rd_d;
    logic        wr_q,    wr_d;
    logic [31:0] lba_q,   lba_d;
    logic [23:0] cnt_q,   cnt_d;

    logic [1:0]  pend;
    logic        sel;
    logic [1:0]  owner_oh;
    logic        timeout_hit;

    assign pend     = rd_req | wr_req;
    // With both requesters pending the round-robin pointer decides. Otherwise
    // the single pending requester wins.
    assign sel      = (pend == 2'b11) ? rr_q : pend[1];
    assign owner_oh = owner_q ? 2'b10 : 2'b01;
    assign timeout_hit = (cnt_q == TO_LAST) && !sd_ack;

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            grant_q <= 2'b00;
            err_q   <= 2'b00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lba_q   <= 32'd0;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        err_d   = 2'b00;
        rd_d    = rd_q;
        wr_d    = wr_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // sd_ack is deliberately not looked at here.
                if (pend != 2'b00) begin
                    state_d = S_REQ;
                    owner_d = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    lba_d   = sel ? lba_1 : lba_0;
                    // A requester asking for both operations gets a read.
                    rd_d    = rd_req[sel];
                    wr_d    = !rd_req[sel];
                    cnt_d   = 24'd0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 24'd1;
                if (sd_ack) begin
                    state_d = S_XFER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (timeout_hit) begin
                    // Abort leaves rr untouched so the same requester keeps
                    // its priority when it retries.
                    state_d = S_IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    grant_d = 2'b00;
                    err_d   = owner_oh;
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = !owner_q;
                grant_d = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        done        = 2'b00;
        buff_wr     = 2'b00;
        sd_buff_din = 8'h00;
        if (state_q == S_DONE) begin
            done = owner_oh;
        end
        if (state_q == S_XFER) begin
            buff_wr     = owner_q ? {sd_buff_wr, 1'b0} : {1'b0, sd_buff_wr};
            sd_buff_din = owner_q ? din_1 : din_0;
        end
    end

    assign grant  = grant_q;
    assign err    = err_q;
    assign sd_rd  = rd_q;
    assign sd_wr  = wr_q;
    assign sd_lba = lba_q;

endmodule

// File: tb/tb_mist_sd_arbiter.sv
// Testbench for mist_sd_arbiter: a cycle-by-cycle vector table covering
// arbitration, round-robin and op selection. Hand-written sequences follow for
// the long transfer, byte streaming, timeout abort and reset mid-transfer.
module tb_mist_sd_arbiter;

    localparam logic [31:0] L0 = 32'h0000_1234;
    localparam logic [31:0] L1 = 32'hABCD_0001;
    localparam logic [7:0]  D0 = 8'h11;
    localparam logic [7:0]  D1 = 8'h22;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  rd_req, wr_req;
    logic [31:0] lba_0, lba_1;
    logic [7:0]  din_0, din_1;
    logic [1:0]  grant, done, err, buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int n_tests = 0;
    int n_fail  = 0;

    mist_sd_arbiter #(.TIMEOUT(24'd16)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .lba_0      (lba_0),
        .lba_1      (lba_1),
        .din_0      (din_0),
        .din_1      (din_1),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .buff_wr    (buff_wr),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .sd_buff_wr (sd_buff_wr),
        .sd_buff_din(sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        bwr;
        logic [1:0]  grant;
        logic [1:0]  done;
        logic [1:0]  err;
        logic        srd;
        logic        swr;
        logic [1:0]  bw;
        logic [7:0]  bdin;
        logic [31:0] lba;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic ack,
                       input logic bwr, input logic [1:0] g, input logic [1:0] d,
                       input logic [1:0] e, input logic srd, input logic swr,
                       input logic [1:0] bw, input logic [7:0] bdin, input logic [31:0] lba);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ack = ack; v.bwr = bwr;
        v.grant = g; v.done = d; v.err = e; v.srd = srd; v.swr = swr;
        v.bw = bw; v.bdin = bdin; v.lba = lba;
        vecs.push_back(v);
    endtask

    function automatic logic [49:0] outs();
        return {grant, done, err, sd_rd, sd_wr, buff_wr, sd_buff_din, sd_lba};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    int bad;

    initial begin
        reset = 1'b1; rd_req = 2'b00; wr_req = 2'b00;
        lba_0 = L0; lba_1 = L1; din_0 = D0; din_1 = D1;
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        step(); step();
        chk("reset_state", 64'(outs()), 64'd0);
        reset = 1'b0;

        //   rd     wr     ack   bwr   grant  done   err    srd   swr   bw     bdin  lba
        add(2'b01, 2'b10, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00, L0);
        add(2'b01, 2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D0,    L0);
        add(2'b01, 2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, D0,    L0);
        add(2'b01, 2'b10, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L0);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L0);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 8'h00, L1);
        add(2'b00, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D1,    L1);
        add(2'b00, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, D1,    L1);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        // rr is back at 0; requester 0 asks for both ops -> read
        add(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00, L0);
        add(2'b01, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D0,    L0);
        add(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L0);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L0);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 8'h00, L1);
        add(2'b00, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D1,    L1);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        // ack high while idle is ignored
        add(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        add(2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00, L1);
        add(2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D1,    L1);
        add(2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        // requester 0 re-requests back-to-back; it must yield to requester 1
        add(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00, L0);
        add(2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D0,    L0);
        add(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L0);
        add(2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L0);
        add(2'b01, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 8'h00, L1);
        add(2'b00, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, D1,    L1);
        add(2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, L1);

        for (int i = 0; i < vecs.size(); i++) begin
            rd_req = vecs[i].rd; wr_req = vecs[i].wr;
            sd_ack = vecs[i].ack; sd_buff_wr = vecs[i].bwr;
            step();
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].grant, vecs[i].done, vecs[i].err, vecs[i].srd, vecs[i].swr,
                     vecs[i].bw, vecs[i].bdin, vecs[i].lba}));
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0; rd_req = 2'b00; wr_req = 2'b00;

        // Long read by requester 0; lba_0 changes after the latch
        rd_req = 2'b01;
        step();
        chk("h1_req", 64'({grant, sd_rd, sd_wr, sd_lba}), 64'({2'b01, 1'b1, 1'b0, L0}));
        lba_0 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("h1_hold%0d", i), 64'({grant, sd_rd, sd_lba}), 64'({2'b01, 1'b1, L0}));
        end
        sd_ack = 1'b1;
        step();
        chk("h1_ack", 64'({grant, sd_rd, done}), 64'({2'b01, 1'b0, 2'b00}));
        bad = 0;
        for (int i = 0; i < 511; i++) begin
            step();
            if (grant !== 2'b01 || done !== 2'b00 || sd_rd !== 1'b0 || sd_lba !== L0) bad++;
        end
        chk("h1_xfer_bad_cycles", 64'(bad), 64'd0);
        sd_ack = 1'b0;
        step();
        chk("h1_done", 64'({grant, done}), 64'({2'b01, 2'b01}));
        rd_req = 2'b00;
        step();
        chk("h1_idle", 64'({grant, done}), 64'({2'b00, 2'b00}));
        lba_0 = L0;

        // Requester 1 write with a 512-byte stream
        wr_req = 2'b10;
        step();
        chk("h2_req", 64'({grant, sd_rd, sd_wr, sd_lba}), 64'({2'b10, 1'b0, 1'b1, L1}));
        sd_ack = 1'b1;
        step();
        bad = 0;
        for (int a = 0; a < 512; a++) begin
            logic [8:0] addr;
            addr = 9'(a);
            din_1 = addr[7:0];
            sd_buff_wr = 1'b1;
            #1;
            if (buff_wr !== 2'b10 || sd_buff_din !== addr[7:0]) bad++;
            sd_buff_wr = 1'b0;
            #1;
            if (buff_wr !== 2'b00) bad++;
            step();
        end
        chk("h2_stream_bad", 64'(bad), 64'd0);
        sd_ack = 1'b0;
        step();
        chk("h2_done", 64'({grant, done}), 64'({2'b10, 2'b10}));
        sd_buff_wr = 1'b1; din_1 = 8'hFF;
        #1;
        chk("h2_outside_xfer", 64'({buff_wr, sd_buff_din}), 64'({2'b00, 8'h00}));
        sd_buff_wr = 1'b0; din_1 = D1; wr_req = 2'b00;
        step();

        // Timeout abort for requester 0; rr stays at 0
        rd_req = 2'b01;
        step();
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (sd_rd !== 1'b1 || err !== 2'b00 || done !== 2'b00) bad++;
        end
        chk("h3_wait_bad", 64'(bad), 64'd0);
        step();
        chk("h3_abort", 64'({sd_rd, err, grant, done}), 64'({1'b0, 2'b01, 2'b00, 2'b00}));
        rd_req = 2'b00;
        step();
        chk("h3_pulse", 64'({err, done}), 64'({2'b00, 2'b00}));
        rd_req = 2'b01; wr_req = 2'b10;
        step();
        chk("h3_rr_kept", 64'({grant, sd_rd, sd_wr}), 64'({2'b01, 1'b1, 1'b0}));

        // Reset 100 cycles into XFER
        sd_ack = 1'b1;
        step();
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (grant !== 2'b01 || done !== 2'b00) bad++;
        end
        chk("h4_xfer_bad", 64'(bad), 64'd0);
        reset = 1'b1; sd_buff_wr = 1'b1;
        step();
        chk("h4_reset", 64'(outs()), 64'd0);
        reset = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        step();
        chk("h4_regrant", 64'({grant, done, sd_rd, sd_lba}), 64'({2'b01, 2'b00, 1'b1, L0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
